// File: rtl/vending_buy_ctrl.sv
// vending_buy_ctrl: purchase decision, credit/stock bookkeeping, timed dispense strobe and change return.
module vending_buy_ctrl #(
    parameter int CREDIT_W    = 12,
    parameter int PRICE0      = 300,
    parameter int PRICE1      = 500,
    parameter int PRICE2      = 700,
    parameter int PRICE3      = 1200,
    parameter int STOCK_INIT  = 5,
    parameter int DISP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          buy_pulse,
    input  logic [2:0]          coin_pulse,
    input  logic                return_pulse,
    input  logic                restock_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          stock0,
    output logic [3:0]          stock1,
    output logic [3:0]          stock2,
    output logic [3:0]          stock3,
    output logic [3:0]          dispense,
    output logic                busy,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                change_valid,
    output logic                sold_out,
    output logic                short_credit,
    output logic                coin_reject
);
    localparam int CW = DISP_CYCLES > 1 ? $clog2(DISP_CYCLES) : 1;
    // Sum width holds credit plus the largest coin sum (1600) without wrapping.
    localparam int SW = (CREDIT_W > 11 ? CREDIT_W : 11) + 1;
    localparam logic [SW-1:0] CMAX = SW'({CREDIT_W{1'b1}});
    localparam logic [3:0] SINIT = 4'(STOCK_INIT);

    typedef enum logic {IDLE, DISPENSE} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic [3:0]          stock [4];
    logic [3:0]          stock_nx [4];
    logic [CREDIT_W-1:0] credit_nx, change_amt_nx, price, after_buy;
    logic [3:0]          dispense_nx;
    logic                cv_nx, so_nx, sc_nx, cr_nx;
    logic [1:0]          sel;
    logic                has_buy, accept, ret_ok;
    logic [10:0]         coin_sum;
    logic [SW-1:0]       total;

    assign has_buy  = |buy_pulse;
    assign sel      = buy_pulse[0] ? 2'd0 : buy_pulse[1] ? 2'd1 : buy_pulse[2] ? 2'd2 : 2'd3;
    assign price    = sel == 2'd0 ? CREDIT_W'(PRICE0) : sel == 2'd1 ? CREDIT_W'(PRICE1) :
                      sel == 2'd2 ? CREDIT_W'(PRICE2) : CREDIT_W'(PRICE3);
    assign coin_sum = (coin_pulse[0] ? 11'd100 : 11'd0) + (coin_pulse[1] ? 11'd500 : 11'd0) +
                      (coin_pulse[2] ? 11'd1000 : 11'd0);
    assign busy     = state == DISPENSE;
    assign stock0   = stock[0];
    assign stock1   = stock[1];
    assign stock2   = stock[2];
    assign stock3   = stock[3];

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        credit_nx     = credit;
        stock_nx      = stock;
        dispense_nx   = dispense;
        change_amt_nx = change_amt;
        cv_nx         = 1'b0;
        so_nx         = 1'b0;
        sc_nx         = 1'b0;
        cr_nx         = 1'b0;
        accept        = 1'b0;
        ret_ok        = 1'b0;
        after_buy     = credit;
        total         = SW'(credit);
        if (state == DISPENSE) begin
            if (cnt == '0) begin
                state_nx    = IDLE;
                dispense_nx = '0;
            end else begin
                cnt_nx = cnt - CW'(1);
            end
        end else begin
            so_nx     = has_buy && stock[sel] == 4'd0;
            sc_nx     = has_buy && stock[sel] != 4'd0 && credit < price;
            accept    = has_buy && stock[sel] != 4'd0 && credit >= price;
            after_buy = accept ? credit - price : credit;
            ret_ok    = return_pulse && !has_buy && credit != '0;
            total     = SW'(after_buy) + SW'(coin_sum);
            // A return consumes the old credit, so coins arriving with it are refused.
            cr_nx     = coin_pulse != 3'd0 && (ret_ok || total > CMAX);
            credit_nx = ret_ok ? '0 : cr_nx ? after_buy : total[CREDIT_W-1:0];
            if (accept) begin
                stock_nx[sel] = stock[sel] - 4'd1;
                dispense_nx   = 4'b0001 << sel;
                state_nx      = DISPENSE;
                cnt_nx        = CW'(DISP_CYCLES - 1);
            end
            if (ret_ok) begin
                change_amt_nx = credit;
                cv_nx         = 1'b1;
            end
            if (restock_pulse) stock_nx = '{SINIT, SINIT, SINIT, SINIT};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            credit       <= '0;
            stock        <= '{SINIT, SINIT, SINIT, SINIT};
            dispense     <= '0;
            change_amt   <= '0;
            change_valid <= 1'b0;
            sold_out     <= 1'b0;
            short_credit <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            credit       <= credit_nx;
            stock        <= stock_nx;
            dispense     <= dispense_nx;
            change_amt   <= change_amt_nx;
            change_valid <= cv_nx;
            sold_out     <= so_nx;
            short_credit <= sc_nx;
            coin_reject  <= cr_nx;
        end
    end
endmodule
